st_mac_pipe: RTL

Parametrised, fully handshaked successor to the three-input Avalon-ST multiply-add. It joins three operand streams A, B, C and pushes the results through a pipelined multiplier into an output FIFO. Back-pressure from the result sink is honoured without loss. The block runs in one of two modes, chosen by parameter:
- MAC: one result per beat, R = A*B + C.
- DOT: packet dot-product, R = C(first beat) + Σ A*B.

---
 rtl/mac_pkg.sv | 15 +
 rtl/st_sync_fifo.sv | 60 ++++++
 rtl/st_mac_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the st_mac_pipe multiply-add block.
//   mode_e : selects per-beat multiply-add (MAC_MODE) or packet dot-product (DOT_MODE)
//   out_w  : result width, 2*data_w + guard_w
package mac_pkg;

  typedef enum logic [0:0] {
    MAC_MODE = 1'b0,
    DOT_MODE = 1'b1
  } mode_e;

  function automatic int out_w(input int data_w, input int guard_w);
    return (2 * data_w) + guard_w;
  endfunction

endpackage

// File: rtl/st_sync_fifo.sv
// st_sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en      : write request; accepted when not full, or when full and a read
//                frees the head slot on the same edge
//   wr_data    : WIDTH-bit write data
//   rd_en      : read (pop) request; ignored while empty
//   rd_data    : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
module st_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_wr_s;
  logic             do_rd_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= do_wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= do_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end
  end

  // Storage array; contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/st_mac_pipe.sv
// st_mac_pipe: three-stream Avalon-ST multiply-add with pipelined multiplier
// and credit-protected output FIFO.
//   csi_clk, rsi_reset_n         : clock, asynchronous active-low reset
//   asi_in0_* (data/valid/ready/startofpacket/endofpacket) : operand A + framing
//   asi_in1_* (data/valid/ready) : operand B
//   asi_in2_* (data/valid/ready) : operand C
//   aso_out0_* (data/valid/ready): result R, show-ahead from the output FIFO
// MAC_MODE: R = A*B + C per beat. DOT_MODE: R = C(sop) + sum(A*B), emitted on eop.
module st_mac_pipe
  import mac_pkg::*;
#(
  parameter int    DATA_W     = 8,
  parameter int    GUARD_W    = 8,
  parameter int    PIPE       = 2,
  parameter int    FIFO_DEPTH = 4,
  parameter mode_e MODE       = MAC_MODE
) (
  input  logic                                 csi_clk,
  input  logic                                 rsi_reset_n,
  input  logic [DATA_W-1:0]                    asi_in0_data,
  input  logic                                 asi_in0_valid,
  output logic                                 asi_in0_ready,
  input  logic                                 asi_in0_startofpacket,
  input  logic                                 asi_in0_endofpacket,
  input  logic [DATA_W-1:0]                    asi_in1_data,
  input  logic                                 asi_in1_valid,
  output logic                                 asi_in1_ready,
  input  logic [DATA_W-1:0]                    asi_in2_data,
  input  logic                                 asi_in2_valid,
  output logic                                 asi_in2_ready,
  output logic [out_w(DATA_W, GUARD_W)-1:0]    aso_out0_data,
  output logic                                 aso_out0_valid,
  input  logic                                 aso_out0_ready
);

  localparam int OUT_W  = out_w(DATA_W, GUARD_W);
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LAST   = PIPE - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               all_valid_s;
  logic               credit_ok_s;
  logic               fire_s;
  logic               pop_s;
  logic               result_inc_s;
  logic [CNT_W-1:0]   cnt_r;

  logic [PROD_W-1:0]  prod_r [PIPE];
  logic [DATA_W-1:0]  c_r    [PIPE];
  logic [PIPE-1:0]    sop_r;
  logic [PIPE-1:0]    eop_r;
  logic [PIPE-1:0]    bval_r;

  logic [OUT_W-1:0]   ext_p_s;
  logic [OUT_W-1:0]   ext_c_s;
  logic [OUT_W-1:0]   acc_r;
  logic [OUT_W-1:0]   acc_next_s;
  logic [OUT_W-1:0]   result_s;
  logic               wr_en_s;
  logic               fifo_wr_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [OUT_W-1:0]   fifo_head_s;

  // Join and credit. cnt_r reserves a FIFO slot for every result already
  // launched, so the pipeline never has to stall; a pop in the same cycle
  // frees a slot early, which keeps full rate with a shallow FIFO.
  assign all_valid_s  = asi_in0_valid & asi_in1_valid & asi_in2_valid;
  assign pop_s        = ~fifo_empty_s & aso_out0_ready;
  assign credit_ok_s  = (cnt_r < CNT_MAX) | ((cnt_r == CNT_MAX) & pop_s);
  assign fire_s       = all_valid_s & credit_ok_s & rsi_reset_n;
  assign result_inc_s = fire_s & ((MODE == MAC_MODE) ? 1'b1 : asi_in0_endofpacket);

  assign asi_in0_ready = fire_s;
  assign asi_in1_ready = fire_s;
  assign asi_in2_ready = fire_s;

  // Credit counter: results in flight plus FIFO occupancy.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({result_inc_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Multiplier pipeline; the product travels with C, framing and beat-valid.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      for (int i = 0; i < PIPE; i++) begin
        prod_r[i] <= {PROD_W{1'b0}};
        c_r[i]    <= {DATA_W{1'b0}};
      end
      sop_r  <= {PIPE{1'b0}};
      eop_r  <= {PIPE{1'b0}};
      bval_r <= {PIPE{1'b0}};
    end else begin
      prod_r[0] <= PROD_W'(asi_in0_data) * PROD_W'(asi_in1_data);
      c_r[0]    <= asi_in2_data;
      sop_r[0]  <= asi_in0_startofpacket;
      eop_r[0]  <= asi_in0_endofpacket;
      bval_r[0] <= fire_s;
      for (int i = 1; i < PIPE; i++) begin
        prod_r[i] <= prod_r[i-1];
        c_r[i]    <= c_r[i-1];
        sop_r[i]  <= sop_r[i-1];
        eop_r[i]  <= eop_r[i-1];
        bval_r[i] <= bval_r[i-1];
      end
    end
  end

  assign ext_p_s = OUT_W'(prod_r[LAST]);
  assign ext_c_s = OUT_W'(c_r[LAST]);

  // Final stage: form the result and decide whether it enters the FIFO.
  // A sop always restarts the accumulator, which also discards any partial
  // packet that never saw its eop.
  always_comb begin
    acc_next_s = acc_r;
    result_s   = {OUT_W{1'b0}};
    wr_en_s    = 1'b0;
    if (MODE == MAC_MODE) begin
      result_s = ext_c_s + ext_p_s;
      wr_en_s  = bval_r[LAST];
    end else begin
      if (sop_r[LAST]) begin
        acc_next_s = ext_c_s + ext_p_s;
      end else begin
        acc_next_s = acc_r + ext_p_s;
      end
      result_s = acc_next_s;
      wr_en_s  = bval_r[LAST] & eop_r[LAST];
    end
  end

  // Dot-product accumulator, advanced by every beat reaching the final stage.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      acc_r <= {OUT_W{1'b0}};
    end else if ((MODE == DOT_MODE) && bval_r[LAST]) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // The credit scheme guarantees space; the full gate is a second line of defence.
  assign fifo_wr_s = wr_en_s & (~fifo_full_s | pop_s);

  st_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (csi_clk),
    .rst_n   (rsi_reset_n),
    .wr_en   (fifo_wr_s),
    .wr_data (result_s),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Head is masked while empty so the data bus reads zero in and after reset.
  assign aso_out0_valid = ~fifo_empty_s;
  assign aso_out0_data  = fifo_empty_s ? {OUT_W{1'b0}} : fifo_head_s;

endmodule
